// File: rtl/i2s_dac_transmitter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pkg
// Description : Shared width, channel and state encodings for the I2S DAC path.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    localparam int I2S_DATA_WIDTH = 24;

    typedef enum logic [0:0] {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_ch_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } i2s_tx_state_e;

endpackage
`default_nettype wire

// File: rtl/i2s_dac_transmitter_fifo.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx_fifo
// Description : Synchronous stereo-pair FIFO with registered full flag and level.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_full_level = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_level;
    logic [c_ptr_w:0]   w_level_next;
    logic               r_full;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_push = i_push && !r_full;
    assign w_do_pop  = i_pop && (r_level != '0);

    always_comb begin
        w_level_next = r_level;
        if (w_do_push && !w_do_pop) begin
            w_level_next = r_level + 1'b1;
        end else if (w_do_pop && !w_do_push) begin
            w_level_next = r_level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= w_level_next;
            // Full is decided from the next level so ready drops right after the last slot fills
            r_full  <= (w_level_next == c_full_level);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/i2s_dac_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : i2s_dac_transmitter
// Description : I2S slave serialiser for WM8731 DACDAT. Macro I2S_TX_HOLD_LAST_EN
//               repeats the last pair on underflow instead of muting.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_dac_transmitter
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = I2S_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_aud_bclk,
    input  logic                          i_aud_daclrck,
    output logic                          o_aud_dacdat,
    input  logic                          i_sample_valid,
    input  logic [DATA_WIDTH-1:0]         i_sample_left,
    input  logic [DATA_WIDTH-1:0]         i_sample_right,
    output logic                          o_sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_underflow
);

    logic r_bclk_meta, r_bclk_sync, r_bclk_hist;
    logic r_lr_meta, r_lr_sync, r_lr_prev;
    logic w_bclk_fall, w_lr_edge, w_left_start, w_right_start;
    i2s_ch_e w_lr_now;

    i2s_tx_state_e           r_state, w_state_next;
    logic [DATA_WIDTH-1:0]   r_shift, w_shift_next;
    logic [DATA_WIDTH-1:0]   r_hold_l, w_hold_l_next;
    logic [DATA_WIDTH-1:0]   r_hold_r, w_hold_r_next;
    logic                    r_dacdat, w_dacdat_next;
    logic                    r_underflow, w_underflow;

    logic [2*DATA_WIDTH-1:0] w_fifo_rd_data;
    logic                    w_fifo_full, w_fifo_empty, w_push, w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bclk_meta <= 1'b0;
            r_bclk_sync <= 1'b0;
            r_bclk_hist <= 1'b0;
            r_lr_meta   <= 1'b0;
            r_lr_sync   <= 1'b0;
            r_lr_prev   <= 1'b0;
        end else begin
            r_bclk_meta <= i_aud_bclk;
            r_bclk_sync <= r_bclk_meta;
            r_bclk_hist <= r_bclk_sync;
            r_lr_meta   <= i_aud_daclrck;
            r_lr_sync   <= r_lr_meta;
            if (w_bclk_fall) begin
                r_lr_prev <= r_lr_sync;
            end
        end
    end

    assign w_bclk_fall   = r_bclk_hist && !r_bclk_sync;
    assign w_lr_now      = i2s_ch_e'(r_lr_sync);
    assign w_lr_edge     = w_bclk_fall && (r_lr_sync != r_lr_prev);
    assign w_left_start  = w_lr_edge && (w_lr_now == CH_LEFT);
    assign w_right_start = w_lr_edge && (w_lr_now == CH_RIGHT);

    assign o_sample_ready = !w_fifo_full;
    assign w_push         = i_sample_valid && o_sample_ready;

    i2s_tx_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({i_sample_left, i_sample_right}),
        .o_data  (w_fifo_rd_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (o_fifo_level)
    );

    // The frame-start fall drives 0 (one-BCLK I2S delay); zeros shifted in give the padding
    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_hold_l_next = r_hold_l;
        w_hold_r_next = r_hold_r;
        w_dacdat_next = r_dacdat;
        w_pop         = 1'b0;
        w_underflow   = 1'b0;
        if (w_left_start) begin
            w_state_next  = ST_SHIFT;
            w_dacdat_next = 1'b0;
            if (!w_fifo_empty) begin
                w_pop         = 1'b1;
                w_hold_l_next = w_fifo_rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
                w_hold_r_next = w_fifo_rd_data[DATA_WIDTH-1:0];
                w_shift_next  = w_fifo_rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
            end else begin
                w_underflow = 1'b1;
`ifdef I2S_TX_HOLD_LAST_EN
                w_shift_next = r_hold_l;
`else
                w_hold_l_next = '0;
                w_hold_r_next = '0;
                w_shift_next  = '0;
`endif
            end
        end else if (w_bclk_fall && (r_state == ST_SHIFT)) begin
            if (w_right_start) begin
                w_dacdat_next = 1'b0;
                w_shift_next  = r_hold_r;
            end else begin
                w_dacdat_next = r_shift[DATA_WIDTH-1];
                w_shift_next  = r_shift << 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_hold_l    <= '0;
            r_hold_r    <= '0;
            r_dacdat    <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_shift     <= w_shift_next;
            r_hold_l    <= w_hold_l_next;
            r_hold_r    <= w_hold_r_next;
            r_dacdat    <= w_dacdat_next;
            r_underflow <= w_underflow;
        end
    end

    assign o_aud_dacdat = r_dacdat;
    assign o_underflow  = r_underflow;

endmodule
`default_nettype wire
